// File: rtl/req_ack_responder.sv
// Request/acknowledge responder: a one-cycle ack follows each accepted req rise by DELAY edges.
// If an ack cannot be issued when it comes due, it waits in a saturating pending counter.
module req_ack_responder #(
    parameter int DELAY    = 3,
    parameter int MAX_PEND = 8,
    parameter int PEND_W   = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              req,
    input  logic              stall,
    output logic              ack,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow,
    output logic [CNT_W-1:0]  ack_cnt
);
    localparam int STAGES = DELAY - 1;
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

    logic              req_q;
    logic [STAGES-1:0] tok;
    logic              launch;
    logic              mature;
    logic              pend_empty;
    logic              pend_full;
    logic              drain;
    logic              direct;
    logic              defer;
    logic              issue;

    // A maturing token may take the ack slot only when nothing is queued ahead of it.
    // This keeps acks in order and guarantees ack is never high on two consecutive edges.
    assign launch     = en & req & ~req_q;
    assign mature     = tok[STAGES-1];
    assign pend_empty = (pend_cnt == '0);
    assign pend_full  = (pend_cnt == PEND_MAX);
    assign drain      = ~stall & ~pend_empty & ~ack;
    assign direct     = mature & ~stall & pend_empty & ~ack;
    assign defer      = mature & ~direct;
    assign issue      = drain | direct;

    assign busy = (|tok) | ~pend_empty | ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= 1'b0;
            tok      <= '0;
            ack      <= 1'b0;
            pend_cnt <= '0;
            overflow <= 1'b0;
            ack_cnt  <= '0;
        end else begin
            req_q  <= req;
            tok[0] <= launch;
            for (int i = 1; i < STAGES; i++) begin
                tok[i] <= tok[i-1];
            end

            ack <= issue;
            if (issue) begin
                ack_cnt <= ack_cnt + CNT_W'(1);
            end

            // A drain coinciding with a deferral frees the slot the new token takes.
            if (drain && !defer) begin
                pend_cnt <= pend_cnt - PEND_W'(1);
            end else if (defer && !drain) begin
                if (pend_full) begin
                    overflow <= 1'b1;
                end else begin
                    pend_cnt <= pend_cnt + PEND_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench for req_ack_responder: a default instance (DELAY=3, MAX_PEND=8) and a
// small instance (MAX_PEND=2, CNT_W=2) share stimulus; edge k means the k-th posedge after reset release.
module tb_req_ack_responder;
    logic        clk;
    logic        rst_n;
    logic        en;
    logic        req;
    logic        stall;
    logic        ack;
    logic        busy;
    logic [3:0]  pend_cnt;
    logic        overflow;
    logic [15:0] ack_cnt;
    logic        s_ack;
    logic        s_busy;
    logic [3:0]  s_pend_cnt;
    logic        s_overflow;
    logic [1:0]  s_ack_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int cur   = 0;

    req_ack_responder #(.DELAY(3), .MAX_PEND(8), .PEND_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .stall(stall),
        .ack(ack), .busy(busy), .pend_cnt(pend_cnt), .overflow(overflow), .ack_cnt(ack_cnt)
    );

    req_ack_responder #(.DELAY(3), .MAX_PEND(2), .PEND_W(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .stall(stall),
        .ack(s_ack), .busy(s_busy), .pend_cnt(s_pend_cnt), .overflow(s_overflow), .ack_cnt(s_ack_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At each negedge the outputs show what edge `cur` samples, and inputs set here are sampled by it.
    task automatic advance();
        @(negedge clk);
        cur++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cur   = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ack: got %0b expected 0", ack); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (pend_cnt !== 4'd0) begin n_bad++; $display("[TB] FAIL reset_pend: got %0d expected 0", pend_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
        n_cmp++; if (ack_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL reset_ack_cnt: got %0d expected 0", ack_cnt); end
        req = 1'b1;
        advance();
        req = 1'b0;
        advance();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL async_busy_before: got %0b expected 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL async_busy_after: got %0b expected 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic ea;
        logic eb;
        do_reset();
        while (cur <= 10) begin
            req = (cur == 4);
            ea  = (cur == 7);
            eb  = (cur >= 5 && cur <= 7);
            n_cmp++; if (ack !== ea) begin n_bad++; $display("[TB] FAIL single_ack edge %0d: got %0b expected %0b", cur, ack, ea); end
            n_cmp++; if (busy !== eb) begin n_bad++; $display("[TB] FAIL single_busy edge %0d: got %0b expected %0b", cur, busy, eb); end
            advance();
        end
        n_cmp++; if (ack_cnt !== 16'd1) begin n_bad++; $display("[TB] FAIL single_ack_cnt: got %0d expected 1", ack_cnt); end
    endtask

    task automatic test_back_to_back();
        logic ea;
        do_reset();
        while (cur <= 15) begin
            req = (cur == 2 || cur == 6 || cur == 10);
            ea  = (cur == 5 || cur == 9 || cur == 13);
            n_cmp++; if (ack !== ea) begin n_bad++; $display("[TB] FAIL b2b_ack edge %0d: got %0b expected %0b", cur, ack, ea); end
            n_cmp++; if (pend_cnt !== 4'd0) begin n_bad++; $display("[TB] FAIL b2b_pend edge %0d: got %0d expected 0", cur, pend_cnt); end
            advance();
        end
        n_cmp++; if (ack_cnt !== 16'd3) begin n_bad++; $display("[TB] FAIL b2b_ack_cnt: got %0d expected 3", ack_cnt); end
    endtask

    task automatic test_stall();
        logic ea;
        int   ep;
        do_reset();
        while (cur <= 28) begin
            stall = (cur <= 20);
            req   = (cur == 2 || cur == 6 || cur == 10);
            ea    = (cur == 22 || cur == 24 || cur == 26);
            n_cmp++; if (ack !== ea) begin n_bad++; $display("[TB] FAIL stall_ack edge %0d: got %0b expected %0b", cur, ack, ea); end
            if (cur == 12 || cur == 13 || cur == 21 || cur == 22 || cur == 24 || cur == 26) begin
                ep = (cur == 12) ? 2 : (cur == 13 || cur == 21) ? 3 : (cur == 22) ? 2 : (cur == 24) ? 1 : 0;
                n_cmp++; if (pend_cnt !== 4'(ep)) begin n_bad++; $display("[TB] FAIL stall_pend edge %0d: got %0d expected %0d", cur, pend_cnt, ep); end
            end
            advance();
        end
        n_cmp++; if (ack_cnt !== 16'd3) begin n_bad++; $display("[TB] FAIL stall_ack_cnt: got %0d expected 3", ack_cnt); end
    endtask

    task automatic test_drain_and_mature();
        logic ea;
        int   ep;
        do_reset();
        while (cur <= 16) begin
            stall = (cur <= 8);
            req   = (cur == 2 || cur == 6 || cur == 9);
            ea    = (cur == 10 || cur == 12 || cur == 14);
            n_cmp++; if (ack !== ea) begin n_bad++; $display("[TB] FAIL dm_ack edge %0d: got %0b expected %0b", cur, ack, ea); end
            if (cur >= 9 && cur <= 14) begin
                ep = (cur == 9) ? 2 : (cur == 14) ? 0 : 1;
                n_cmp++; if (pend_cnt !== 4'(ep)) begin n_bad++; $display("[TB] FAIL dm_pend edge %0d: got %0d expected %0d", cur, pend_cnt, ep); end
            end
            advance();
        end
        n_cmp++; if (ack_cnt !== 16'd3) begin n_bad++; $display("[TB] FAIL dm_ack_cnt: got %0d expected 3", ack_cnt); end
    endtask

    task automatic test_overflow();
        int s_acks;
        s_acks = 0;
        do_reset();
        while (cur <= 30) begin
            stall = (cur <= 13);
            req   = (cur == 2 || cur == 6 || cur == 10);
            if (cur == 12) begin
                n_cmp++; if (s_pend_cnt !== 4'd2) begin n_bad++; $display("[TB] FAIL ovf_pend_pre: got %0d expected 2", s_pend_cnt); end
                n_cmp++; if (s_overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_flag_pre: got %0b expected 0", s_overflow); end
            end
            if (cur == 13) begin
                n_cmp++; if (s_pend_cnt !== 4'd2) begin n_bad++; $display("[TB] FAIL ovf_pend_sat: got %0d expected 2", s_pend_cnt); end
                n_cmp++; if (s_overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_flag_set: got %0b expected 1", s_overflow); end
                n_cmp++; if (pend_cnt !== 4'd3) begin n_bad++; $display("[TB] FAIL ovf_big_pend: got %0d expected 3", pend_cnt); end
                n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_big_flag: got %0b expected 0", overflow); end
            end
            if (s_ack === 1'b1) s_acks++;
            advance();
        end
        n_cmp++; if (s_acks != 2) begin n_bad++; $display("[TB] FAIL ovf_ack_count: got %0d expected 2", s_acks); end
        n_cmp++; if (s_overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", s_overflow); end
        n_cmp++; if (ack_cnt !== 16'd3) begin n_bad++; $display("[TB] FAIL ovf_big_ack_cnt: got %0d expected 3", ack_cnt); end
        do_reset();
        n_cmp++; if (s_overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_cleared: got %0b expected 0", s_overflow); end
    endtask

    task automatic test_enable();
        logic ea;
        do_reset();
        while (cur <= 26) begin
            en  = (cur >= 21);
            req = (cur >= 3 && cur <= 5) || (cur == 21);
            ea  = (cur == 24);
            n_cmp++; if (ack !== ea) begin n_bad++; $display("[TB] FAIL en_ack edge %0d: got %0b expected %0b", cur, ack, ea); end
            if (cur <= 21) begin
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL en_busy edge %0d: got %0b expected 0", cur, busy); end
            end
            if (cur == 20) begin
                n_cmp++; if (ack_cnt !== 16'd0) begin n_bad++; $display("[TB] FAIL en_ack_cnt_off: got %0d expected 0", ack_cnt); end
            end
            advance();
        end
        n_cmp++; if (ack_cnt !== 16'd1) begin n_bad++; $display("[TB] FAIL en_ack_cnt_on: got %0d expected 1", ack_cnt); end
    endtask

    task automatic test_reset_mid_flight();
        logic ea;
        do_reset();
        while (cur <= 14) begin
            req = (cur >= 4);
            if (cur == 5) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_busy_inflight: got %0b expected 1", busy); end
            end
            if (cur == 6) begin
                rst_n = 1'b0;
                #1;
                n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_busy_reset: got %0b expected 0", busy); end
            end
            if (cur == 8) rst_n = 1'b1;
            ea = (cur == 11);
            n_cmp++; if (ack !== ea) begin n_bad++; $display("[TB] FAIL mid_ack edge %0d: got %0b expected %0b", cur, ack, ea); end
            advance();
        end
        n_cmp++; if (ack_cnt !== 16'd1) begin n_bad++; $display("[TB] FAIL mid_ack_cnt: got %0d expected 1", ack_cnt); end
        req = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        while (cur <= 24) begin
            req = (cur == 2 || cur == 6 || cur == 10 || cur == 14 || cur == 18);
            if (cur == 16) begin
                n_cmp++; if (s_ack_cnt !== 2'd3) begin n_bad++; $display("[TB] FAIL wrap_pre: got %0d expected 3", s_ack_cnt); end
            end
            if (cur == 17) begin
                n_cmp++; if (s_ack_cnt !== 2'd0) begin n_bad++; $display("[TB] FAIL wrap_zero: got %0d expected 0", s_ack_cnt); end
                n_cmp++; if (ack_cnt !== 16'd4) begin n_bad++; $display("[TB] FAIL wrap_big4: got %0d expected 4", ack_cnt); end
            end
            advance();
        end
        n_cmp++; if (s_ack_cnt !== 2'd1) begin n_bad++; $display("[TB] FAIL wrap_after: got %0d expected 1", s_ack_cnt); end
        n_cmp++; if (ack_cnt !== 16'd5) begin n_bad++; $display("[TB] FAIL wrap_big5: got %0d expected 5", ack_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 1'b0;
        stall = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_drain_and_mature();
        test_overflow();
        test_enable();
        test_reset_mid_flight();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
